// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port between IF-stage
// instruction fetch and MEM-stage load/store. MEM has priority, and a streak
// counter bounds how long IF can be starved. Each access is a req/ack
// transaction with a watchdog abort, followed by a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic [1:0]  d_rd,
  input  logic [1:0]  d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        err
);

  // Streak counter is at least 3 bits wide; wait counter just covers TIMEOUT.
  localparam int SW = ($clog2(STREAK_MAX + 1) < 3) ? 3 : $clog2(STREAK_MAX + 1);
  localparam int WW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, DONE} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wait_cnt;

  logic d_pend;
  logic mem_wins;
  logic timed_out;

  assign d_pend    = (d_rd != 2'b00) || (d_wr != 2'b00);
  // MEM wins unless IF has been passed over STREAK_MAX times in a row.
  assign mem_wins  = d_pend && ((streak < SW'(STREAK_MAX)) || !if_req);
  assign timed_out = (wait_cnt == WW'(TIMEOUT));

  // Stalls follow the live requests so the hazard unit sees them in cycle 0.
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = d_pend & ~d_ready;

  // Arbitration FSM with registered memory-port, ready and read-data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      wait_cnt <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_size   <= 2'b00;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every decision below uses the
      // pre-edge register values regardless of statement order.
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_wins) begin
            state    <= GNT_MEM;
            m_req    <= 1'b1;
            m_we     <= (d_wr != 2'b00);
            m_size   <= (d_wr != 2'b00) ? d_wr : d_rd;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            wait_cnt <= '0;
            if (!if_req) begin
              streak <= '0;
            end else if (streak < SW'(STREAK_MAX)) begin
              streak <= streak + SW'(1);
            end
          end else if (if_req) begin
            state    <= GNT_IF;
            m_req    <= 1'b1;
            m_we     <= 1'b0;
            m_size   <= 2'b11;
            m_addr   <= if_addr;
            m_wdata  <= 32'h0;
            wait_cnt <= '0;
            streak   <= '0;
          end
        end
        GNT_IF, GNT_MEM: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= DONE;
            if (state == GNT_IF) begin
              if_rdata <= m_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!m_we) d_rdata <= m_rdata;
              d_ready <= 1'b1;
            end
          end else if (timed_out) begin
            // Abort: the requester still gets its ready, with zero data.
            m_req <= 1'b0;
            err   <= 1'b1;
            state <= DONE;
            if (state == GNT_IF) begin
              if_rdata <= 32'h0;
              if_ready <= 1'b1;
            end else begin
              d_rdata <= 32'h0;
              d_ready <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DONE: begin
          // Requesters advance during this cycle; nothing is sampled here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A memory responder acks after a
// programmable number of m_req cycles; a scoreboard monitor matches every
// ready pulse against the queue of expected completions.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_ready;
  logic [1:0]  d_rd, d_wr;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready;
  logic        m_req, m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ack;
  logic        if_stall, mem_stall, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int ack_delay = 0;  // 0 = never ack, n = ack in n-th m_req cycle
  bit spur      = 0;  // drive m_ack while no grant is active

  mem_port_arbiter #(.STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .if_stall(if_stall), .mem_stall(mem_stall), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_data, input logic [31:0] v);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = v;
    sb_q.push_back(e);
  endtask

  // Memory contents seen by the bench: word at address a is 0x0B000005 + a.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'h0B00_0005 + a;
  endfunction

  // Memory responder.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    m_ack   = 1'b0;
    m_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (m_req === 1'b1) begin
        acc_cnt++;
        if (ack_delay != 0 && acc_cnt == ack_delay) begin
          m_ack   = 1'b1;
          m_rdata = mem_val(m_addr);
        end else begin
          m_ack   = 1'b0;
          m_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        acc_cnt = 0;
        m_ack   = spur;
        m_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        check("sb_single_ready", 32'(if_ready & d_ready), 0);
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ready", 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          check("sb_kind", 32'(d_ready), 32'(e.is_data));
          check("sb_rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_ready(input bit data, input int budget, output int cyc);
    bit seen;
    cyc  = 0;
    seen = 0;
    while (cyc < budget && !seen) begin
      @(negedge clk);
      cyc++;
      seen = data ? (d_ready === 1'b1) : (if_ready === 1'b1);
    end
    if (!seen) check("ready_timeout", 32'(seen), 1);
  endtask

  task automatic wait_any(input int budget, output bit got_data);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    got_data = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        ok = 1;
        got_data = d_ready;
      end
    end
    if (!ok) check("any_ready_timeout", 32'(ok), 1);
  endtask

  initial begin
    int       cyc, mreq_n;
    bit       got;
    bit [5:0] seq;

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_rd = 2'b00; d_wr = 2'b00; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_m_req", 32'(m_req), 0);
    check("rst_m_we", 32'(m_we), 0);
    check("rst_m_size", 32'(m_size), 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_err", 32'(err), 0);
    check("rst_ready", 32'(if_ready | d_ready), 0);
    rst = 1'b0;

    // m_ack outside a grant is ignored
    spur = 1;
    repeat (3) @(negedge clk);
    check("spur_m_req", 32'(m_req), 0);
    check("spur_err", 32'(err), 0);
    spur = 0;
    @(negedge clk);

    // Fetch with zero-wait memory
    ack_delay = 1; if_req = 1'b1; if_addr = 32'h0;
    push_exp(0, 32'h0B00_0005);
    #1;
    check("t1_stall_c0", 32'(if_stall), 1);
    check("t1_mreq_c0", 32'(m_req), 0);
    @(negedge clk);
    check("t1_mreq_c1", 32'(m_req), 1);
    check("t1_size_c1", 32'(m_size), 3);
    check("t1_stall_c1", 32'(if_stall), 1);
    @(negedge clk);
    check("t1_mreq_c2", 32'(m_req), 0);
    check("t1_ready_c2", 32'(if_ready), 1);
    check("t1_rdata_c2", if_rdata, 32'h0B00_0005);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_ready_c3", 32'(if_ready), 0);

    // Load vs fetch collision: MEM first, then IF
    d_rd = 2'b11; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h4;
    push_exp(1, 32'h0B00_0045);
    push_exp(0, 32'h0B00_0009);
    #1;
    check("t2_if_stall_c0", 32'(if_stall), 1);
    check("t2_mem_stall_c0", 32'(mem_stall), 1);
    @(negedge clk);
    check("t2_addr_c1", m_addr, 32'h40);
    check("t2_we_c1", 32'(m_we), 0);
    check("t2_if_stall_c1", 32'(if_stall), 1);
    @(negedge clk);
    check("t2_d_ready_c2", 32'(d_ready), 1);
    check("t2_mem_stall_c2", 32'(mem_stall), 0);
    check("t2_if_stall_c2", 32'(if_stall), 1);
    d_rd = 2'b00;
    @(negedge clk);
    check("t2_if_stall_c3", 32'(if_stall), 1);
    @(negedge clk);
    check("t2_addr_c4", m_addr, 32'h4);
    check("t2_mreq_c4", 32'(m_req), 1);
    check("t2_if_stall_c4", 32'(if_stall), 1);
    @(negedge clk);
    check("t2_if_ready_c5", 32'(if_ready), 1);
    if_req = 1'b0;
    @(negedge clk);

    // Starvation bound: 4 MEM, then 1 IF, then MEM again
    d_rd = 2'b11; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h100;
    push_exp(1, 32'h0B00_0205);
    push_exp(1, 32'h0B00_0209);
    push_exp(1, 32'h0B00_020D);
    push_exp(1, 32'h0B00_0211);
    push_exp(0, 32'h0B00_0105);
    push_exp(1, 32'h0B00_0215);
    seq = '0;
    for (int t = 0; t < 6; t++) begin
      wait_any(8, got);
      seq[t] = got;
      if (got) d_addr = d_addr + 32'h4;
      else     if_addr = if_addr + 32'h4;
    end
    if_req = 1'b0; d_rd = 2'b00;
    check("t3_grant_order", 32'(seq), 32'b10_1111);
    @(negedge clk);

    // Store with two wait states; port signals latched for the whole grant
    ack_delay = 3; d_wr = 2'b11; d_addr = 32'h10; d_wdata = 32'h1234_5678;
    push_exp(1, 32'h0B00_0215);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t4_mreq", 32'(m_req), 1);
      check("t4_we", 32'(m_we), 1);
      check("t4_size", 32'(m_size), 3);
      check("t4_addr", m_addr, 32'h10);
      check("t4_wdata", m_wdata, 32'h1234_5678);
      if (c == 1) begin
        d_addr = 32'hFFFF_FFF0; d_wdata = 32'hCAFE_F00D;
      end
    end
    @(negedge clk);
    check("t4_d_ready", 32'(d_ready), 1);
    check("t4_mreq_done", 32'(m_req), 0);
    d_wr = 2'b00; d_addr = '0; d_wdata = '0;
    @(negedge clk);

    // Timeout with TIMEOUT = 8: m_req cycles 1..9, ready in cycle 10
    ack_delay = 0; if_req = 1'b1; if_addr = 32'h20;
    push_exp(0, 32'h0);
    cyc = 0; mreq_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (m_req === 1'b1) mreq_n++;
      if (cyc == 9) check("t5_err_before", 32'(err), 0);
    end while (if_ready !== 1'b1 && cyc < 20);
    check("t5_ready_cycle", cyc, 10);
    check("t5_mreq_cycles", mreq_n, 9);
    check("t5_err", 32'(err), 1);
    if_req = 1'b0;
    @(negedge clk);

    // Following byte load completes normally; err stays set
    ack_delay = 2; d_rd = 2'b01; d_addr = 32'h30;
    push_exp(1, 32'h0B00_0035);
    @(negedge clk);
    check("t5b_size", 32'(m_size), 1);
    check("t5b_we", 32'(m_we), 0);
    wait_ready(1, 8, cyc);
    check("t5b_latency", cyc, 2);
    check("t5b_err_sticky", 32'(err), 1);
    d_rd = 2'b00;
    @(negedge clk);

    // Reset in the middle of a MEM grant
    ack_delay = 0; d_rd = 2'b10; d_addr = 32'h50;
    @(negedge clk);
    check("t6_mreq_c1", 32'(m_req), 1);
    @(negedge clk);
    check("t6_mreq_c2", 32'(m_req), 1);
    rst = 1'b1; d_rd = 2'b00;
    @(negedge clk);
    check("t6_m_req", 32'(m_req), 0);
    check("t6_m_we", 32'(m_we), 0);
    check("t6_m_size", 32'(m_size), 0);
    check("t6_m_addr", m_addr, 0);
    check("t6_m_wdata", m_wdata, 0);
    check("t6_if_rdata", if_rdata, 0);
    check("t6_d_rdata", d_rdata, 0);
    check("t6_err", 32'(err), 0);
    check("t6_d_ready", 32'(d_ready), 0);
    rst = 1'b0;
    ack_delay = 1; if_req = 1'b1; if_addr = 32'h60;
    push_exp(0, 32'h0B00_0065);
    wait_ready(0, 8, cyc);
    check("t6_fetch_latency", cyc, 2);
    if_req = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
